// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared byte-banked data memory between the fetch port and the load/store port,
// tracks reads through the fixed memory latency and steers each returned word to its requester.
`ifndef DATAWIDTH_BYTE
`define DATAWIDTH_BYTE  2'b00
`endif
`ifndef DATAWIDTH_SHORT
`define DATAWIDTH_SHORT 2'b01
`endif
`ifndef DATAWIDTH_WORD
`define DATAWIDTH_WORD  2'b10
`endif

module mem_port_arbiter #(
    parameter int  DATA_DEPTH      = 4096,
    parameter int  READ_LATENCY    = 3,
    parameter int  MAX_DATA_STREAK = 4,
    localparam int ADDR_WIDTH      = 2 + $clog2(DATA_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req_valid,
    output logic                  if_req_ready,
    input  logic [ADDR_WIDTH-1:0] if_req_addr,
    output logic                  if_rsp_valid,
    output logic [31:0]           if_rsp_data,
    input  logic                  d_req_valid,
    output logic                  d_req_ready,
    input  logic                  d_req_we,
    input  logic [1:0]            d_req_width,
    input  logic [ADDR_WIDTH-1:0] d_req_addr,
    input  logic [31:0]           d_req_wdata,
    output logic                  d_rsp_valid,
    output logic [31:0]           d_rsp_data,
    output logic                  mem_we,
    output logic [1:0]            mem_data_width,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_write_data,
    input  logic [31:0]           mem_read_data
);

    localparam int              SW         = $clog2(MAX_DATA_STREAK + 1);
    localparam logic [SW-1:0]   STREAK_MAX = SW'(MAX_DATA_STREAK);

    logic                    grant_if;
    logic                    grant_d;
    logic                    bubble_q, bubble_d;
    logic [SW-1:0]           streak_q, streak_d;
    logic [READ_LATENCY-1:0] vld_q, vld_d;
    logic [READ_LATENCY-1:0] port_q, port_d;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [1:0]              width_q;
    logic [31:0]             if_data_q, d_data_q;
    logic                    rsp_vld;
    logic                    rsp_port;

    always_comb begin
        grant_if = 1'b0;
        grant_d  = 1'b0;
        if (!rst && !bubble_q) begin
            if (if_req_valid && d_req_valid) begin
                if (streak_q == STREAK_MAX) grant_if = 1'b1;
                else                        grant_d  = 1'b1;
            end else begin
                grant_if = if_req_valid;
                grant_d  = d_req_valid;
            end
        end
    end

    assign if_req_ready = grant_if;
    assign d_req_ready  = grant_d;

    // Address and width hold their last driven value on idle cycles.
    always_comb begin
        mem_we         = grant_d & d_req_we;
        mem_write_data = d_req_wdata;
        mem_addr       = addr_q;
        mem_data_width = width_q;
        if (grant_if) begin
            mem_addr       = if_req_addr;
            mem_data_width = `DATAWIDTH_WORD;
        end else if (grant_d) begin
            mem_addr       = d_req_addr;
            mem_data_width = d_req_width;
        end
    end

    always_comb begin
        if (grant_if || !if_req_valid)  streak_d = '0;
        else if (grant_d)               streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + SW'(1);
        else                            streak_d = streak_q;
    end

    // The memory commits stores a cycle late, so the cycle after a store issues nothing.
    assign bubble_d = grant_d & d_req_we;

    always_comb begin
        vld_d     = '0;
        port_d    = '0;
        vld_d[0]  = grant_if | (grant_d & ~d_req_we);
        port_d[0] = grant_d;
        for (int i = 1; i < READ_LATENCY; i++) begin
            vld_d[i]  = vld_q[i-1];
            port_d[i] = port_q[i-1];
        end
    end

    assign rsp_vld      = vld_q[READ_LATENCY-1];
    assign rsp_port     = port_q[READ_LATENCY-1];
    assign if_rsp_valid = rsp_vld & ~rsp_port;
    assign d_rsp_valid  = rsp_vld & rsp_port;
    assign if_rsp_data  = if_rsp_valid ? mem_read_data : if_data_q;
    assign d_rsp_data   = d_rsp_valid  ? mem_read_data : d_data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_q  <= 1'b0;
            streak_q  <= '0;
            vld_q     <= '0;
            port_q    <= '0;
            if_data_q <= '0;
            d_data_q  <= '0;
        end else begin
            bubble_q <= bubble_d;
            streak_q <= streak_d;
            vld_q    <= vld_d;
            port_q   <= port_d;
            if (if_rsp_valid) if_data_q <= mem_read_data;
            if (d_rsp_valid)  d_data_q  <= mem_read_data;
        end
    end

    always_ff @(posedge clk) begin
        addr_q  <= mem_addr;
        width_q <= mem_data_width;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a byte-banked memory model (3-cycle reads, late write commit).
module tb_mem_port_arbiter;

    localparam int         AW     = 14;
    localparam int         NB     = 16384;
    localparam logic [1:0] W_BYTE = 2'b00;
    localparam logic [1:0] W_WORD = 2'b10;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req_valid, if_req_ready, if_rsp_valid;
    logic [AW-1:0] if_req_addr;
    logic [31:0]   if_rsp_data;
    logic          d_req_valid, d_req_ready, d_req_we, d_rsp_valid;
    logic [1:0]    d_req_width;
    logic [AW-1:0] d_req_addr;
    logic [31:0]   d_req_wdata, d_rsp_data;
    logic          mem_we;
    logic [1:0]    mem_data_width;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_write_data, mem_read_data;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
        .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_we(d_req_we),
        .d_req_width(d_req_width), .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata),
        .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data),
        .mem_we(mem_we), .mem_data_width(mem_data_width), .mem_addr(mem_addr),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
    );

    // Memory model: little-endian byte array, reads return 4 raw bytes from addr
    logic [7:0]    mem_m [0:NB-1];
    logic [31:0]   rd_p0, rd_p1, rd_p2;
    logic          pend_we = 1'b0;
    logic [AW-1:0] pend_addr;
    logic [1:0]    pend_w;
    logic [31:0]   pend_data;
    logic          pl_we = 1'b0;
    logic [AW-1:0] pl_addr;
    logic [31:0]   pl_data;

    assign mem_read_data = rd_p2;

    function automatic int nbytes(input logic [1:0] w);
        case (w)
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic [31:0] rdword(input logic [AW-1:0] a);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) r[8*k +: 8] = mem_m[a + AW'(k)];
        return r;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (pend_we && k < nbytes(pend_w)) mem_m[pend_addr + AW'(k)] <= pend_data[8*k +: 8];
            if (pl_we) mem_m[pl_addr + AW'(k)] <= pl_data[8*k +: 8];
        end
        pend_we   <= mem_we;
        pend_addr <= mem_addr;
        pend_w    <= mem_data_width;
        pend_data <= mem_write_data;
        rd_p0     <= rdword(mem_addr);
        rd_p1     <= rd_p0;
        rd_p2     <= rd_p1;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        port;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   n_cmp    = 0;
    int   n_err    = 0;
    int   rsp_seen = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string nm);
        n_cmp++;
        n_err++;
        $display("FAIL %s: bound expired at cycle %0d", nm, cyc);
    endtask

    // Monitor: every response pulse pops the oldest expectation
    initial begin
        exp_t        e;
        logic [31:0] got;
        forever begin
            @(negedge clk);
            if (if_rsp_valid || d_rsp_valid) begin
                rsp_seen++;
                n_cmp++;
                got = d_rsp_valid ? d_rsp_data : if_rsp_data;
                if (if_rsp_valid && d_rsp_valid) begin
                    n_err++;
                    $display("FAIL rsp_both: both response valids high at cycle %0d", cyc);
                end else if (q.size() == 0) begin
                    n_err++;
                    $display("FAIL rsp_unexpected: port %0d data %h at cycle %0d, none expected", d_rsp_valid, got, cyc);
                end else begin
                    e = q.pop_front();
                    if (e.port !== d_rsp_valid || e.data !== got || e.cyc != cyc) begin
                        n_err++;
                        $display("FAIL rsp: got port %0d data %h cycle %0d, expected port %0d data %h cycle %0d",
                                 d_rsp_valid, got, cyc, e.port, e.data, e.cyc);
                    end
                end
            end
        end
    end

    task automatic preload(input logic [AW-1:0] a, input logic [31:0] d);
        pl_we = 1'b1; pl_addr = a; pl_data = d;
        @(posedge clk); #1;
        pl_we = 1'b0;
    endtask

    task automatic issue_if(input logic [AW-1:0] a, input logic push, input logic [31:0] ed, output int acc);
        acc = -1;
        if_req_valid = 1'b1;
        if_req_addr  = a;
        for (int t = 0; t < 20 && acc < 0; t++) begin
            @(negedge clk);
            if (if_req_ready) begin
                acc = cyc;
                if (push) q.push_back('{port: 1'b0, data: ed, cyc: cyc + 3});
            end
            @(posedge clk); #1;
        end
        if_req_valid = 1'b0;
        if (acc < 0) timeout_fail("if_accept");
    endtask

    task automatic issue_d(input logic we, input logic [1:0] w, input logic [AW-1:0] a, input logic [31:0] wd,
                           input logic push, input logic [31:0] ed, output int acc);
        acc = -1;
        d_req_valid = 1'b1; d_req_we = we; d_req_width = w; d_req_addr = a; d_req_wdata = wd;
        for (int t = 0; t < 20 && acc < 0; t++) begin
            @(negedge clk);
            if (d_req_ready) begin
                acc = cyc;
                if (push) q.push_back('{port: 1'b1, data: ed, cyc: cyc + 3});
            end
            @(posedge clk); #1;
        end
        d_req_valid = 1'b0;
        d_req_we    = 1'b0;
        if (acc < 0) timeout_fail("d_accept");
    endtask

    task automatic drain();
        for (int t = 0; t < 30 && q.size() != 0; t++) @(posedge clk);
        if (q.size() != 0) timeout_fail("drain");
        @(posedge clk); #1;
    endtask

    initial begin
        int a0, a1, a2, seen0;
        int di, fj, k;
        logic got_f;

        rst = 1'b1;
        if_req_valid = 1'b0; if_req_addr = '0;
        d_req_valid = 1'b0; d_req_we = 1'b0; d_req_width = W_WORD; d_req_addr = '0; d_req_wdata = '0;

        // Reset: requests presented while in reset are never granted
        @(posedge clk); #1;
        if_req_valid = 1'b1; d_req_valid = 1'b1; d_req_we = 1'b1;
        @(negedge clk);
        chk("rst_if_ready", if_req_ready, 1'b0);
        chk("rst_d_ready", d_req_ready, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_if_rsp_valid", if_rsp_valid, 1'b0);
        chk("rst_d_rsp_valid", d_rsp_valid, 1'b0);
        chk("rst_rsp_data", if_rsp_data | d_rsp_data, 32'h0);
        @(posedge clk); #1;
        if_req_valid = 1'b0; d_req_valid = 1'b0; d_req_we = 1'b0;
        preload(14'h010, 32'h11223344);
        rst = 1'b0;
        @(posedge clk); #1;

        // Single fetch
        issue_if(14'h010, 1'b1, 32'h11223344, a0);
        drain();
        chk("if_data_hold", if_rsp_data, 32'h11223344);

        // Misaligned store, then a load that must wait out the bubble
        issue_d(1'b1, W_WORD, 14'h021, 32'hDEADBEEF, 1'b0, 32'h0, a0);
        d_req_valid = 1'b1; d_req_we = 1'b0; d_req_width = W_WORD; d_req_addr = 14'h021;
        @(negedge clk);
        chk("raw_bubble_stall", d_req_ready, 1'b0);
        @(posedge clk); #1;
        issue_d(1'b0, W_WORD, 14'h021, 32'h0, 1'b1, 32'hDEADBEEF, a1);
        chk("load_accept_cycle", a1, a0 + 2);
        drain();

        // Starvation bound: D,D,D,D,F repeating
        for (int i = 0; i < 8; i++) preload(14'h100 + 14'(4*i), 32'hD000_0000 + i);
        for (int j = 0; j < 2; j++) preload(14'h200 + 14'(4*j), 32'hF000_0000 + j);
        di = 0; fj = 0; k = 0;
        if_req_valid = 1'b1; if_req_addr = 14'h200;
        d_req_valid = 1'b1; d_req_we = 1'b0; d_req_width = W_WORD; d_req_addr = 14'h100;
        for (int t = 0; t < 40 && k < 10; t++) begin
            @(negedge clk);
            if (d_req_ready || if_req_ready) begin
                got_f = if_req_ready;
                chk("grant_seq", got_f, (k % 5 == 4));
                if (got_f) begin
                    q.push_back('{port: 1'b0, data: 32'hF000_0000 + fj, cyc: cyc + 3});
                    fj++;
                end else begin
                    q.push_back('{port: 1'b1, data: 32'hD000_0000 + di, cyc: cyc + 3});
                    di++;
                end
                k++;
            end
            @(posedge clk); #1;
            d_req_addr  = 14'h100 + 14'(4*di);
            if_req_addr = 14'h200 + 14'(4*fj);
        end
        if_req_valid = 1'b0; d_req_valid = 1'b0;
        if (k < 10) timeout_fail("starve_grants");
        drain();

        // Back-to-back fetches
        preload(14'h000, 32'h0A0B0C0D);
        preload(14'h004, 32'h14151617);
        preload(14'h008, 32'h28292A2B);
        issue_if(14'h000, 1'b1, 32'h0A0B0C0D, a0);
        issue_if(14'h004, 1'b1, 32'h14151617, a1);
        issue_if(14'h008, 1'b1, 32'h28292A2B, a2);
        chk("b2b_accept_1", a1, a0 + 1);
        chk("b2b_accept_2", a2, a1 + 1);
        drain();

        // Reset with two loads in flight
        issue_d(1'b0, W_WORD, 14'h040, 32'h0, 1'b0, 32'h0, a0);
        issue_d(1'b0, W_WORD, 14'h044, 32'h0, 1'b0, 32'h0, a1);
        seen0 = rsp_seen;
        rst = 1'b1;
        d_req_valid = 1'b1; d_req_we = 1'b1; d_req_width = W_WORD; d_req_addr = 14'h040;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            chk("rstmid_mem_we", mem_we, 1'b0);
            chk("rstmid_d_ready", d_req_ready, 1'b0);
            chk("rstmid_d_rsp_valid", d_rsp_valid, 1'b0);
            @(posedge clk); #1;
        end
        d_req_valid = 1'b0; d_req_we = 1'b0;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("rstmid_no_rsp", rsp_seen, seen0);

        // Byte store merged into a zero word
        preload(14'h010, 32'h00000000);
        issue_d(1'b1, W_BYTE, 14'h013, 32'h000000AB, 1'b0, 32'h0, a0);
        issue_d(1'b0, W_WORD, 14'h010, 32'h0, 1'b1, 32'hAB000000, a1);
        drain();

        chk("queue_empty", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port byte-banked data memory group between two requesters: the instruction-fetch port (read-only, word) and the load/store port (read/write, byte/short/word).
- Issues at most one access per cycle.
- Tracks in-flight reads through the memory's fixed read latency and routes each returned word to the requester that issued it.
- Enforces read-after-write ordering and bounds fetch starvation.

Parameters:
- DATA_DEPTH, 4096, words per bank of the attached memory group; ADDR_WIDTH = 2+$clog2(DATA_DEPTH) (byte address).
- READ_LATENCY, 3, cycles from the issue cycle to the cycle in which mem_read_data is valid.
- MAX_DATA_STREAK, 4, maximum consecutive data-port grants while a fetch request is waiting.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- if_req_valid  in  1  fetch request
- if_req_ready  out  1  fetch request accepted this cycle
- if_req_addr  in  ADDR_WIDTH  fetch byte address
- if_rsp_valid  out  1  fetch data valid (single-cycle pulse)
- if_rsp_data  out  32  fetch data
- d_req_valid  in  1  load/store request
- d_req_ready  out  1  load/store accepted this cycle
- d_req_we  in  1  1=store, 0=load
- d_req_width  in  2  `DATAWIDTH_BYTE/SHORT/WORD
- d_req_addr  in  ADDR_WIDTH  byte address, misalignment allowed
- d_req_wdata  in  32  store data, LSB-aligned
- d_rsp_valid  out  1  load data valid (single-cycle pulse; never asserted for stores)
- d_rsp_data  out  32  load data (raw word; sign/zero extension is the consumer's job)
- mem_we  out  1  to memory group we
- mem_data_width  out  2  to memory group data_width
- mem_addr  out  ADDR_WIDTH  to memory group addr
- mem_write_data  out  32  to memory group write_data
- mem_read_data  in  32  from memory group read_data

Behaviour:
- Clocking and reset:
  - Single clock.
  - Reset is asynchronous, active-high.
  - While rst is high: if_req_ready=0, d_req_ready=0, mem_we=0, rsp_valids=0, rsp_data=0, streak counter=0, bubble flag=0, in-flight pipe cleared.
  - Reset mid-operation discards all in-flight reads; no rsp_valid fires for them after reset deasserts.
- Grant (combinational, in the cycle the request is presented):
  - No grant when bubble=1 or rst=1.
  - Only one port valid -> grant it.
  - Both valid -> grant data unless streak==MAX_DATA_STREAK, in which case grant fetch.
  - ready is high only for the granted port; accept = valid & ready.
  - Requesters hold their request stable until accepted.
- Memory drive (combinational from the grant):
  - Fetch grant: mem_addr=if_req_addr, mem_data_width=`DATAWIDTH_WORD, mem_we=0.
  - Data grant: d_req_* passed through, with mem_we=d_req_we.
  - No grant: mem_we=0; mem_addr and mem_data_width hold their last values.
- Streak counter:
  - Data grant while if_req_valid=1: increment, saturating at MAX_DATA_STREAK.
  - Any fetch grant, or if_req_valid=0: clear to 0.
- Read-after-write bubble:
  - Any accepted store sets bubble=1 for exactly the next cycle, with no grant to either port. The memory commits writes one cycle late; the bubble keeps a following read from observing stale data.
  - Back-to-back stores are therefore issued every other cycle.
- In-flight tracking:
  - A READ_LATENCY-deep shift register carries {valid, port_id} per issue slot.
  - Stores and idle cycles enter as invalid.
  - A read accepted in cycle C produces a 1-cycle rsp_valid on its port in cycle C+READ_LATENCY, with rsp_data=mem_read_data sampled and registered in that cycle. rsp_data holds its last value otherwise.
  - Responses return in issue order.
  - There is no response backpressure; consumers must accept.
  - Throughput is one read per cycle; up to READ_LATENCY reads may be outstanding.
- Simultaneous events:
  - A response may fire in the same cycle as a new grant on the same port; both occur.
  - if_rsp_valid and d_rsp_valid are never both high in the same cycle.

Test Plan:
- Reset, preload, single fetch: assert rst, preload word 0x11223344 at byte address 0x10. Fetch at 0x10 accepted in cycle C -> if_rsp_valid exactly in C+3, if_rsp_data=0x11223344; d_rsp_valid stays 0.
- Misaligned store then load: word store of 0xDEADBEEF at 0x21, immediately followed by a load at 0x21. The load is stalled one bubble cycle (d_req_ready=0), then accepted -> d_rsp_valid 3 cycles after acceptance with d_rsp_data=0xDEADBEEF.
- Starvation bound: fetch and data both valid continuously, loads only, MAX_DATA_STREAK=4. Grant sequence is D,D,D,D,F,D,D,D,D,F...; responses are routed to the matching ports in issue order.
- Back-to-back fetches: 3 consecutive fetches to 0x0, 0x4, 0x8 -> 3 consecutive if_rsp_valid pulses carrying the three words in order, no gaps.
- Reset mid-flight: assert rst one cycle after accepting two loads. No d_rsp_valid after rst deasserts; mem_we=0 throughout reset.
- Byte store merge: store byte 0xAB at 0x13 into word 0x00000000 at 0x10, then load a word at 0x10 -> 0xAB000000.
